// File: rtl/param_load_store_queue_pkg.sv
// rtl/param_load_store_queue_pkg.sv - shared op-type encodings and helpers for the load/store queue
package param_load_store_queue_pkg;

  localparam int LSB_TYPE_W = 3;

  typedef enum logic [LSB_TYPE_W-1:0] {
    LSB_LB  = 3'd0,
    LSB_LH  = 3'd1,
    LSB_LW  = 3'd2,
    LSB_SB  = 3'd3,
    LSB_LBU = 3'd4,
    LSB_LHU = 3'd5,
    LSB_SH  = 3'd6,
    LSB_SW  = 3'd7
  } lsb_type_e;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } lsq_state_e;

  function automatic logic is_store(input logic [LSB_TYPE_W-1:0] op);
    return (op == LSB_SB) || (op == LSB_SH) || (op == LSB_SW);
  endfunction

endpackage

// File: rtl/lsb_load_extend.sv
// rtl/lsb_load_extend.sv - sign/zero extension of raw low-aligned load data by op type
module lsb_load_extend
  import param_load_store_queue_pkg::*;
(
  input  logic [LSB_TYPE_W-1:0] op_type,
  input  logic [31:0]           rdata,
  output logic [31:0]           result
);

  always_comb begin
    result = rdata;
    case (op_type)
      LSB_LB:  result = {{24{rdata[7]}}, rdata[7:0]};
      LSB_LH:  result = {{16{rdata[15]}}, rdata[15:0]};
      LSB_LBU: result = {24'b0, rdata[7:0]};
      LSB_LHU: result = {16'b0, rdata[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/param_load_store_queue.sv
// rtl/param_load_store_queue.sv - in-order load/store queue with two-CDB wake-up and commit-tracked stores
module param_load_store_queue
  import param_load_store_queue_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DEPTH_W = $clog2(DEPTH),
  parameter int ROB_W   = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  output logic                  mc_en,
  output logic [31:0]           mc_addr,
  output logic [LSB_TYPE_W-1:0] mc_type,
  output logic [31:0]           mc_wdata,
  input  logic                  mc_rdy,
  input  logic [31:0]           mc_rdata,
  output logic                  dec_full,
  input  logic                  dec_valid,
  input  logic [LSB_TYPE_W-1:0] dec_type,
  input  logic [31:0]           dec_vj,
  input  logic [31:0]           dec_vk,
  input  logic                  dec_pj,
  input  logic                  dec_pk,
  input  logic [ROB_W-1:0]      dec_qj,
  input  logic [ROB_W-1:0]      dec_qk,
  input  logic [ROB_W-1:0]      dec_rob_id,
  input  logic [31:0]           dec_imm,
  input  logic                  cdb0_en,
  input  logic [ROB_W-1:0]      cdb0_rob_id,
  input  logic [31:0]           cdb0_data,
  input  logic                  cdb1_en,
  input  logic [ROB_W-1:0]      cdb1_rob_id,
  input  logic [31:0]           cdb1_data,
  output logic                  bc_en,
  output logic [ROB_W-1:0]      bc_rob_id,
  output logic [31:0]           bc_data,
  input  logic                  commit_valid,
  input  logic [ROB_W-1:0]      commit_rob_id
);

  localparam int CNT_W = DEPTH_W + 1;

  typedef struct packed {
    logic                  valid;
    logic                  committed;
    logic [LSB_TYPE_W-1:0] op;
    logic [ROB_W-1:0]      rob_id;
    logic [31:0]           vj;
    logic [31:0]           vk;
    logic                  pj;
    logic                  pk;
    logic [ROB_W-1:0]      qj;
    logic [ROB_W-1:0]      qk;
    logic [31:0]           imm;
  } entry_t;

  entry_t             q [DEPTH];
  logic [DEPTH_W-1:0] head;
  logic [DEPTH_W-1:0] tail;
  logic [CNT_W-1:0]   count;
  lsq_state_e         state;
  logic               squash;

  logic               head_go;
  logic               enq;
  logic               deq;
  logic [DEPTH-1:0]   keep;
  logic [CNT_W-1:0]   keep_cnt;
  logic [31:0]        enq_vj;
  logic [31:0]        enq_vk;
  logic               enq_pj;
  logic               enq_pk;
  logic [31:0]        ext_data;

  assign dec_full = (count == CNT_W'(DEPTH));
  assign enq      = rdy_in && dec_valid && !dec_full && !flush;
  assign deq      = rdy_in && (state == ST_WAIT) && mc_rdy;

  // A committed store at head may still issue in a flush cycle; anything else is being discarded.
  assign head_go = q[head].valid && !q[head].pj && !q[head].pk &&
                   (!is_store(q[head].op) || q[head].committed) &&
                   (!flush || q[head].committed);

  always_comb begin
    enq_vj = dec_vj;
    enq_pj = dec_pj;
    if (dec_pj && cdb0_en && (cdb0_rob_id == dec_qj)) begin
      enq_vj = cdb0_data;
      enq_pj = 1'b0;
    end else if (dec_pj && cdb1_en && (cdb1_rob_id == dec_qj)) begin
      enq_vj = cdb1_data;
      enq_pj = 1'b0;
    end
    enq_vk = dec_vk;
    enq_pk = dec_pk;
    if (dec_pk && cdb0_en && (cdb0_rob_id == dec_qk)) begin
      enq_vk = cdb0_data;
      enq_pk = 1'b0;
    end else if (dec_pk && cdb1_en && (cdb1_rob_id == dec_qk)) begin
      enq_vk = cdb1_data;
      enq_pk = 1'b0;
    end
  end

  // Survivors of a flush: committed stores plus whatever op is currently at the memory controller.
  always_comb begin
    keep     = '0;
    keep_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      keep[i]  = q[i].valid && (q[i].committed || ((state == ST_WAIT) && (DEPTH_W'(i) == head)));
      keep_cnt = keep_cnt + CNT_W'(keep[i]);
    end
  end

  lsb_load_extend u_load_extend (
    .op_type (mc_type),
    .rdata   (mc_rdata),
    .result  (ext_data)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      state     <= ST_IDLE;
      squash    <= 1'b0;
      mc_en     <= 1'b0;
      mc_addr   <= '0;
      mc_type   <= '0;
      mc_wdata  <= '0;
      bc_en     <= 1'b0;
      bc_rob_id <= '0;
      bc_data   <= '0;
    end else if (rdy_in) begin
      bc_en <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].valid && q[i].pj) begin
          if (cdb0_en && (cdb0_rob_id == q[i].qj)) begin
            q[i].vj <= cdb0_data;
            q[i].pj <= 1'b0;
          end else if (cdb1_en && (cdb1_rob_id == q[i].qj)) begin
            q[i].vj <= cdb1_data;
            q[i].pj <= 1'b0;
          end
        end
        if (q[i].valid && q[i].pk) begin
          if (cdb0_en && (cdb0_rob_id == q[i].qk)) begin
            q[i].vk <= cdb0_data;
            q[i].pk <= 1'b0;
          end else if (cdb1_en && (cdb1_rob_id == q[i].qk)) begin
            q[i].vk <= cdb1_data;
            q[i].pk <= 1'b0;
          end
        end
        if (commit_valid && q[i].valid && is_store(q[i].op) && (q[i].rob_id == commit_rob_id))
          q[i].committed <= 1'b1;
        if (flush && !keep[i]) begin
          q[i].valid     <= 1'b0;
          q[i].committed <= 1'b0;
        end
      end

      if (enq)
        q[tail] <= '{valid: 1'b1, committed: 1'b0, op: dec_type, rob_id: dec_rob_id,
                     vj: enq_vj, vk: enq_vk, pj: enq_pj, pk: enq_pk,
                     qj: dec_qj, qk: dec_qk, imm: dec_imm};

      case (state)
        ST_IDLE: begin
          if (head_go) begin
            mc_en    <= 1'b1;
            mc_addr  <= q[head].vj + q[head].imm;
            mc_type  <= q[head].op;
            mc_wdata <= q[head].vk;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (flush && !is_store(mc_type)) squash <= 1'b1;
          if (mc_rdy) begin
            mc_en              <= 1'b0;
            state              <= ST_IDLE;
            squash             <= 1'b0;
            q[head].valid      <= 1'b0;
            q[head].committed  <= 1'b0;
            if (!is_store(mc_type) && !squash && !flush) begin
              bc_en     <= 1'b1;
              bc_rob_id <= q[head].rob_id;
              bc_data   <= ext_data;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      head <= head + DEPTH_W'(deq);
      if (flush) begin
        tail  <= head + keep_cnt[DEPTH_W-1:0];
        count <= keep_cnt - CNT_W'(deq);
      end else begin
        tail  <= tail + DEPTH_W'(enq);
        count <= count + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

endmodule

// File: tb/tb_param_load_store_queue.sv
// tb/tb_param_load_store_queue.sv - directed table-driven bench for param_load_store_queue
module tb_param_load_store_queue;
  import param_load_store_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int ROB_W = 4;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              rdy_in;
  logic              flush;
  logic              mc_en;
  logic [31:0]       mc_addr;
  logic [2:0]        mc_type;
  logic [31:0]       mc_wdata;
  logic              mc_rdy;
  logic [31:0]       mc_rdata;
  logic              dec_full;
  logic              dec_valid;
  logic [2:0]        dec_type;
  logic [31:0]       dec_vj, dec_vk, dec_imm;
  logic              dec_pj, dec_pk;
  logic [ROB_W-1:0]  dec_qj, dec_qk, dec_rob_id;
  logic              cdb0_en, cdb1_en;
  logic [ROB_W-1:0]  cdb0_rob_id, cdb1_rob_id;
  logic [31:0]       cdb0_data, cdb1_data;
  logic              bc_en;
  logic [ROB_W-1:0]  bc_rob_id;
  logic [31:0]       bc_data;
  logic              commit_valid;
  logic [ROB_W-1:0]  commit_rob_id;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  param_load_store_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush(flush),
    .mc_en(mc_en), .mc_addr(mc_addr), .mc_type(mc_type), .mc_wdata(mc_wdata),
    .mc_rdy(mc_rdy), .mc_rdata(mc_rdata), .dec_full(dec_full), .dec_valid(dec_valid),
    .dec_type(dec_type), .dec_vj(dec_vj), .dec_vk(dec_vk), .dec_pj(dec_pj), .dec_pk(dec_pk),
    .dec_qj(dec_qj), .dec_qk(dec_qk), .dec_rob_id(dec_rob_id), .dec_imm(dec_imm),
    .cdb0_en(cdb0_en), .cdb0_rob_id(cdb0_rob_id), .cdb0_data(cdb0_data),
    .cdb1_en(cdb1_en), .cdb1_rob_id(cdb1_rob_id), .cdb1_data(cdb1_data),
    .bc_en(bc_en), .bc_rob_id(bc_rob_id), .bc_data(bc_data),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] vj;
    logic [31:0] imm;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } ld_vec_t;

  ld_vec_t lv [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic enq(input logic [2:0] op, input logic [31:0] vj, input logic [31:0] vk,
                     input logic [31:0] imm, input logic pj, input logic pk,
                     input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] rob);
    dec_valid = 1'b1; dec_type = op; dec_vj = vj; dec_vk = vk; dec_imm = imm;
    dec_pj = pj; dec_pk = pk; dec_qj = qj; dec_qk = qk; dec_rob_id = rob;
    @(negedge clk_in);
    dec_valid = 1'b0;
  endtask

  task automatic wait_mc(input string name);
    int n = 0;
    while (!mc_en && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    total++;
    if (!mc_en) begin
      bad++;
      $display("FAIL %s: mc_en got 0 want 1 within 40 cycles", name);
    end
  endtask

  task automatic respond(input logic [31:0] d);
    mc_rdy = 1'b1; mc_rdata = d;
    @(negedge clk_in);
    mc_rdy = 1'b0; mc_rdata = '0;
  endtask

  task automatic idle_no_issue(input string name, input int cycles);
    int hits = 0;
    for (int c = 0; c < cycles; c++) begin
      if (mc_en) hits++;
      @(negedge clk_in);
    end
    check(name, hits, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    lv[0] = '{LSB_LW,  32'h0000_1000, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0000_1004, 32'hDEAD_BEEF};
    lv[1] = '{LSB_LB,  32'h0000_2000, 32'h0000_0000, 32'h0000_0080, 32'h0000_2000, 32'hFFFF_FF80};
    lv[2] = '{LSB_LBU, 32'h0000_2000, 32'h0000_0001, 32'h0000_0080, 32'h0000_2001, 32'h0000_0080};
    lv[3] = '{LSB_LH,  32'hFFFF_FFFC, 32'h0000_0008, 32'h1234_8001, 32'h0000_0004, 32'hFFFF_8001};
    lv[4] = '{LSB_LHU, 32'h0000_3000, 32'hFFFF_FFF0, 32'h1234_8001, 32'h0000_2FF0, 32'h0000_8001};
    lv[5] = '{LSB_LB,  32'h0000_0010, 32'h0000_0020, 32'hFFFF_FF7F, 32'h0000_0030, 32'h0000_007F};
    lv[6] = '{LSB_LW,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    lv[7] = '{LSB_LBU, 32'h0000_0044, 32'h0000_0004, 32'hABCD_EFFE, 32'h0000_0048, 32'h0000_00FE};

    rst_n_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; mc_rdy = 1'b0; mc_rdata = '0;
    dec_valid = 1'b0; dec_type = '0; dec_vj = '0; dec_vk = '0; dec_imm = '0;
    dec_pj = 1'b0; dec_pk = 1'b0; dec_qj = '0; dec_qk = '0; dec_rob_id = '0;
    cdb0_en = 1'b0; cdb0_rob_id = '0; cdb0_data = '0;
    cdb1_en = 1'b0; cdb1_rob_id = '0; cdb1_data = '0;
    commit_valid = 1'b0; commit_rob_id = '0;

    repeat (2) @(negedge clk_in);
    check("rst_mc_en", mc_en, 0);
    check("rst_mc_addr", mc_addr, 0);
    check("rst_mc_type", mc_type, 0);
    check("rst_mc_wdata", mc_wdata, 0);
    check("rst_bc_en", bc_en, 0);
    check("rst_bc_data", bc_data, 0);
    check("rst_bc_rob_id", bc_rob_id, 0);
    check("rst_dec_full", dec_full, 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    for (int i = 0; i < 8; i++) begin
      enq(lv[i].op, lv[i].vj, 32'h5A5A_0000 + i, lv[i].imm, 1'b0, 1'b0, 4'd0, 4'd0, 4'(i + 1));
      wait_mc($sformatf("ld%0d_issue", i));
      check($sformatf("ld%0d_addr", i), mc_addr, lv[i].exp_addr);
      check($sformatf("ld%0d_type", i), mc_type, lv[i].op);
      repeat (2) @(negedge clk_in);
      check($sformatf("ld%0d_hold_en", i), mc_en, 1);
      check($sformatf("ld%0d_hold_addr", i), mc_addr, lv[i].exp_addr);
      respond(lv[i].rdata);
      check($sformatf("ld%0d_bc_en", i), bc_en, 1);
      check($sformatf("ld%0d_bc_data", i), bc_data, lv[i].exp_data);
      check($sformatf("ld%0d_bc_rob", i), bc_rob_id, i + 1);
      @(negedge clk_in);
      check($sformatf("ld%0d_bc_pulse", i), bc_en, 0);
      check($sformatf("ld%0d_count", i), dut.count, 0);
    end

    enq(LSB_SW, 32'h100, 32'hCAFE_F00D, 32'h8, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3);
    idle_no_issue("sw_no_commit", 5);
    commit_valid = 1'b1; commit_rob_id = 4'd4;
    @(negedge clk_in);
    commit_valid = 1'b0;
    idle_no_issue("sw_wrong_tag_commit", 5);
    commit_valid = 1'b1; commit_rob_id = 4'd3;
    @(negedge clk_in);
    commit_valid = 1'b0;
    check("sw_issue_registered", mc_en, 0);
    wait_mc("sw_issue");
    check("sw_addr", mc_addr, 32'h108);
    check("sw_wdata", mc_wdata, 32'hCAFE_F00D);
    check("sw_type", mc_type, LSB_SW);
    respond(32'h0);
    check("sw_no_bc", bc_en, 0);
    check("sw_count", dut.count, 0);

    cdb0_en = 1'b1; cdb0_rob_id = 4'd5; cdb0_data = 32'h2000;
    cdb1_en = 1'b1; cdb1_rob_id = 4'd5; cdb1_data = 32'h9999;
    enq(LSB_LW, 32'h0, 32'h0, 32'h10, 1'b1, 1'b0, 4'd5, 4'd0, 4'd6);
    cdb0_en = 1'b0; cdb1_en = 1'b0;
    wait_mc("cap_issue");
    check("cap_addr", mc_addr, 32'h2010);
    respond(32'h11);
    check("cap_bc_data", bc_data, 32'h11);
    check("cap_bc_rob", bc_rob_id, 6);
    @(negedge clk_in);

    enq(LSB_LW, 32'h0, 32'h0, 32'h24, 1'b1, 1'b0, 4'd7, 4'd0, 4'd8);
    idle_no_issue("snoop_pending", 3);
    cdb1_en = 1'b1; cdb1_rob_id = 4'd7; cdb1_data = 32'h3000;
    @(negedge clk_in);
    cdb1_en = 1'b0;
    wait_mc("snoop_issue");
    check("snoop_addr", mc_addr, 32'h3024);
    respond(32'h55);
    check("snoop_bc_data", bc_data, 32'h55);
    @(negedge clk_in);

    enq(LSB_SW, 32'h500, 32'h0, 32'h0, 1'b0, 1'b1, 4'd0, 4'd9, 4'd10);
    commit_valid = 1'b1; commit_rob_id = 4'd10;
    @(negedge clk_in);
    commit_valid = 1'b0;
    idle_no_issue("snoopk_pending", 3);
    cdb0_en = 1'b1; cdb0_rob_id = 4'd9; cdb0_data = 32'h77;
    @(negedge clk_in);
    cdb0_en = 1'b0;
    wait_mc("snoopk_issue");
    check("snoopk_wdata", mc_wdata, 32'h77);
    respond(32'h0);

    enq(LSB_SW, 32'h600, 32'h1111_1111, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1);
    enq(LSB_SW, 32'h604, 32'h2222_2222, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2);
    enq(LSB_LW, 32'h608, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3);
    check("fl_count_pre", dut.count, 3);
    commit_valid = 1'b1; commit_rob_id = 4'd1;
    @(negedge clk_in);
    commit_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk_in);
    flush = 1'b0;
    check("fl_count", dut.count, 1);
    wait_mc("fl_st_issue");
    check("fl_st_addr", mc_addr, 32'h600);
    check("fl_st_wdata", mc_wdata, 32'h1111_1111);
    respond(32'h0);
    check("fl_st_no_bc", bc_en, 0);
    check("fl_count_post", dut.count, 0);
    idle_no_issue("fl_discarded", 5);

    enq(LSB_LW, 32'h700, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd4);
    wait_mc("flld_issue");
    flush = 1'b1;
    dec_valid = 1'b1; dec_rob_id = 4'd5; dec_vj = 32'h800;
    @(negedge clk_in);
    flush = 1'b0; dec_valid = 1'b0;
    check("flld_hold", mc_en, 1);
    check("flld_count", dut.count, 1);
    respond(32'hAAAA);
    check("flld_no_bc", bc_en, 0);
    check("flld_count_post", dut.count, 0);
    idle_no_issue("flld_enq_ignored", 4);

    for (int i = 0; i < DEPTH; i++)
      enq(LSB_LW, 32'h0, 32'h0, 32'h400 + i * 4, 1'b1, 1'b0, 4'd15, 4'd0, 4'(i));
    check("full_flag", dec_full, 1);
    dec_valid = 1'b1; dec_pj = 1'b0; dec_imm = 32'hBAD0;
    @(negedge clk_in);
    dec_valid = 1'b0;
    check("full_reject_count", dut.count, DEPTH);
    cdb0_en = 1'b1; cdb0_rob_id = 4'd15; cdb0_data = 32'h4000;
    @(negedge clk_in);
    cdb0_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wait_mc($sformatf("drain%0d_issue", i));
      check($sformatf("drain%0d_addr", i), mc_addr, 32'h4400 + i * 4);
      respond(32'(i));
      check($sformatf("drain%0d_rob", i), bc_rob_id, i);
      check($sformatf("drain%0d_data", i), bc_data, i);
      if (i == 0) check("drain_full_drop", dec_full, 0);
    end
    @(negedge clk_in);
    check("drain_count", dut.count, 0);

    enq(LSB_LW, 32'h900, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2);
    wait_mc("rst_wait_issue");
    #2;
    rst_n_in = 1'b0;
    #1;
    check("rst_wait_mc_en", mc_en, 0);
    check("rst_wait_count", dut.count, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    rdy_in = 1'b0;
    enq(LSB_LW, 32'hA00, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1);
    check("rdy_low_hold", dut.count, 0);
    rdy_in = 1'b1;
    idle_no_issue("rdy_low_no_enq", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_load_store_queue.md
Name: param_load_store_queue

Overview:
- Parametrised successor to the core's load/store buffer: an in-order circular queue of memory ops between the decoder and the memory controller.
- Adds configurable depth and tag width, and two-CDB operand wake-up including same-cycle capture at enqueue.
- Adds per-entry store-commit tracking, so committed stores may sit behind the head and still drain.
- On flush, committed stores survive while younger work is discarded. Loads read sub-word data with sign/zero extension.

Parameters:
- DEPTH, 16, queue entries; power of two, >= 2.
- DEPTH_W, $clog2(DEPTH), index width.
- ROB_W, 4, reorder-buffer tag width.

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global enable; when low, all state holds and no handshake completes
- flush  in  1  mispredict squash
- mc_en  out  1  memory request valid; held until mc_rdy
- mc_addr  out  32  request address
- mc_type  out  3  op type (LSB_TYPE encoding)
- mc_wdata  out  32  store data
- mc_rdy  in  1  one-cycle completion pulse
- mc_rdata  in  32  load data, raw, low-aligned
- dec_full  out  1  queue full (count==DEPTH)
- dec_valid  in  1  enqueue request
- dec_type  in  3  op type
- dec_vj, dec_vk  in  32 each  base value, store value
- dec_pj, dec_pk  in  1 each  operand still pending
- dec_qj, dec_qk  in  ROB_W each  producer tags
- dec_rob_id  in  ROB_W  entry tag
- dec_imm  in  32  offset
- cdb0_en/cdb0_rob_id/cdb0_data  in  1/ROB_W/32  ALU broadcast
- cdb1_en/cdb1_rob_id/cdb1_data  in  1/ROB_W/32  LSB broadcast (own output fed back)
- bc_en/bc_rob_id/bc_data  out  1/ROB_W/32  load result broadcast
- commit_valid  in  1  ROB committing this cycle
- commit_rob_id  in  ROB_W  committing tag

Behaviour:
- Reset (async, rst_n_in low): head=tail=count=0, all valid/committed bits 0, FSM=IDLE. All outputs 0, except dec_full=0.
- Enqueue happens when dec_valid && !dec_full. The entry is written at tail and tail wraps mod DEPTH.
- Same-cycle wake-up at enqueue: if dec_pj && cdbX_en && cdbX_rob_id==dec_qj, store the CDB data and clear pending. Same rule for k. If both CDBs match, cdb0 wins.
- Resident entries snoop both CDBs every cycle with the same rule.
- commit_valid sets committed[i] for the valid store entry with rob_id==commit_rob_id. Loads ignore commit.
- Address = vj + imm, modulo 2^32.
- FSM IDLE: if head is valid and both operands are ready, issue in the next cycle. A load needs no further condition; a store additionally needs committed[head]. On issue, register mc_en=1 with addr/type/wdata, and go to WAIT.
- FSM WAIT: outputs held stable until mc_rdy. On mc_rdy: dequeue head, return to IDLE.
  - If the op is a load and not squashed, next cycle bc_en=1, bc_rob_id=tag, bc_data=extended result.
  - Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- bc_en is a single-cycle pulse. Throughput is at most one op per 2 cycles plus memory latency.
- Flush:
  - All uncommitted entries are invalidated and tail = head + (number of committed stores). Committed stores are contiguous from head.
  - An in-flight load keeps mc_en until mc_rdy. It sets a squash flag, its result is dropped (no bc_en), and its entry is freed.
  - An in-flight store completes normally.
  - A dec_valid in the flush cycle is ignored.
- Same-cycle enqueue and dequeue: count unchanged. dec_full is computed from the registered count, so a full queue rejects enqueue even when dequeuing that cycle.
- Wrap-around: head/tail are DEPTH_W bits and count is DEPTH_W+1 bits.
- An async reset in WAIT aborts the request (mc_en goes to 0 immediately).

Decomposition:
- Shared package holds LSB_TYPE_W=3, the type encodings (LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=8-mapped 3, SH=6, SW=7; store = type in {3,6,7}), and the is_store function.
- One sub-module, lsb_load_extend (combinational type+rdata -> result), so the extension can be unit-tested separately.

Test Plan:
- Enqueue LW with vj=0x1000, imm=4, ready -> mc_en with mc_addr=0x1004, type LW. mc_rdy with rdata=0xDEADBEEF -> next cycle bc_en=1, bc_data=0xDEADBEEF, count returns to 0.
- LB with rdata=0x00000080 -> bc_data=0xFFFFFF80; LBU with the same rdata -> 0x00000080.
- Enqueue SW tag 3 (operands ready), no commit for 10 cycles -> mc_en stays 0. Assert commit_valid with rob_id=3 -> mc_en next cycle with wdata=vk.
- Enqueue LW pending on tag 5 while cdb0 broadcasts tag 5 = 0x2000 in the same cycle -> captured, later mc_addr=0x2000+imm.
- Queue holds a committed SW, an uncommitted SW and LW; flush -> count=1, only the committed SW issues. A load in flight at flush -> no bc_en.
- Fill to DEPTH -> dec_full=1, extra dec_valid ignored. Drain with wrap past index DEPTH-1 -> FIFO order preserved, dec_full drops after the first dequeue.
